// File: rtl/sram_like_slave.sv
// sram_like_slave: single-outstanding SRAM-style slave with a fixed or
// pseudo-random response delay, backed by a byte-lane block RAM.
//
// Build option: define MEM_RESP_LFSR_DELAY_EN to draw each request's wait
// count from a 3-bit LFSR (x^3+x^2+1, reset 3'b101) instead of DELAY.
//
// Handshake: a request is taken when req && addr_ok. data_ok pulses one
// cycle, (wait count + 1) cycles after acceptance. rdata is zero except
// during that pulse for a read.
module sram_like_slave #(
    parameter int ADDR_W = 10,
    parameter int DELAY  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [2:0]        cnt_reg, cnt_next;

    // Latched request fields (captured on acceptance only).
    logic              wr_reg;
    logic [ADDR_W-1:0] idx_reg;
    logic [3:0]        wstrb_reg;
    logic [31:0]       wdata_reg;

    logic              accept;
    logic [ADDR_W-1:0] addr_idx;
    logic [ADDR_W-1:0] rd_idx;
    logic [2:0]        wait_cnt;
    logic              mem_we;
    logic [31:0]       rd_word;

    // Bits outside the word index are intentionally ignored (accesses wrap).
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0]};

    assign addr_idx = addr[ADDR_W+1:2];
    assign accept   = (state_reg == IDLE) && req;

`ifdef MEM_RESP_LFSR_DELAY_EN
    logic [2:0] lfsr_reg;
    localparam int unused_delay = DELAY;

    // LFSR steps once per accepted request; the pre-step value is the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_reg <= 3'b101;
        end else if (accept) begin
            lfsr_reg <= {lfsr_reg[1:0], lfsr_reg[2] ^ lfsr_reg[1]};
        end
    end

    assign wait_cnt = lfsr_reg;
`else
    assign wait_cnt = 3'(DELAY);
`endif

    // State and wait counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic: IDLE accepts, WAIT counts down, RESP lasts one cycle.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    if (wait_cnt == 3'd0) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = wait_cnt;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 3'd1;
                if (cnt_reg <= 3'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the request on acceptance; these need no reset because they
    // are only consumed after an acceptance has occurred.
    always_ff @(posedge clk) begin
        if (accept) begin
            wr_reg    <= wr;
            idx_reg   <= addr_idx;
            wstrb_reg <= wstrb;
            wdata_reg <= wdata;
        end
    end

    // While idle, read at the incoming index so a zero-delay request has its
    // word ready in RESP; otherwise keep reading the latched index.
    assign rd_idx = (state_reg == IDLE) ? addr_idx : idx_reg;
    assign mem_we = (state_reg == RESP) && wr_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_lane [2**ADDR_W];
            logic [7:0] rd_lane_reg;

            // Byte lane: write on the edge ending RESP, registered read each cycle.
            always_ff @(posedge clk) begin
                if (mem_we && wstrb_reg[gi]) begin
                    mem_lane[idx_reg] <= wdata_reg[8*gi +: 8];
                end
                rd_lane_reg <= mem_lane[rd_idx];
            end

            assign rd_word[8*gi +: 8] = rd_lane_reg;
        end
    endgenerate

    assign addr_ok = (state_reg == IDLE);
    assign busy    = (state_reg != IDLE);
    assign data_ok = (state_reg == RESP);
    assign rdata   = ((state_reg == RESP) && !wr_reg) ? rd_word : 32'd0;

endmodule

// File: doc/sram_like_slave.md
SRAM_LIKE_SLAVE -- requirements
Module: sram_like_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-index width; the memory holds 2^ADDR_W 32-bit words.
REQ-002 SHALL have parameter DELAY, default 2, fixed wait cycles between address accept and response; legal range 0..7.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  1  the initiator requests a transfer.
REQ-006 SHALL have port wr  input  1  1 = write, 0 = read; sampled with req.
REQ-007 SHALL have port addr  input  32  byte address; the word index is addr[ADDR_W+1:2].
REQ-008 SHALL have port wstrb  input  4  byte write enables, bit i writes wdata[8i+7:8i].
REQ-009 SHALL have port wdata  input  32  write data.
REQ-010 SHALL have port addr_ok  output  1  the request is accepted this cycle when req && addr_ok.
REQ-011 SHALL have port data_ok  output  1  single-cycle response strobe.
REQ-012 SHALL have port rdata  output  32  read data, valid only while data_ok is high.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-015 SHALL drive addr_ok = 1 only in IDLE; in WAIT and RESP it SHALL be 0.
REQ-016 SHALL, in IDLE on req && addr_ok, latch wr, the word index, wstrb and wdata; a wait count of 0 SHALL go to RESP, otherwise the block SHALL load the counter and go to WAIT.
REQ-017 SHALL, in WAIT, decrement the counter each cycle and go to RESP in the cycle after it reaches 1; the response SHALL follow acceptance by exactly (wait count + 1) cycles.
REQ-018 SHALL, in RESP, assert data_ok for exactly one cycle and then return to IDLE; the next request SHALL NOT be accepted before the cycle after RESP.
REQ-019 SHALL, for a read in RESP, drive rdata from the latched word with no combinational path from addr.
REQ-020 SHALL, for a write, update only the enabled bytes at the clock edge ending RESP; rdata SHALL be 0 for writes.
REQ-021 SHALL treat wstrb = 0 on a write as a no-op that still returns data_ok.
REQ-022 SHALL ignore address bits above ADDR_W+1 and bits [1:0]; accesses wrap modulo the memory size.
REQ-023 SHALL hold rdata at 0 whenever data_ok is 0.
REQ-024 SHALL ignore req and the other inputs while busy; no second request is queued.

Reset
REQ-025 SHALL, while rst = 0, force the state to IDLE, addr_ok = 1, data_ok = 0, rdata = 0, busy = 0, counter = 0 and the LFSR to 3'b101.
REQ-026 SHALL, on reset during WAIT or RESP, drop the pending transfer; no write SHALL occur.
REQ-027 SHALL NOT clear memory contents on reset.

Configuration
REQ-028 SHALL, when MEM_RESP_LFSR_DELAY_EN is defined, take the wait count for each accepted request from a 3-bit LFSR (taps x^3+x^2+1), reset value 3'b101, advanced once per acceptance, with the value before advancing used as the count; DELAY SHALL then be ignored.
REQ-029 SHALL, when MEM_RESP_LFSR_DELAY_EN is undefined, use DELAY for every request and omit the LFSR.

Verification
REQ-030 SHALL cover: macro off, DELAY=2, write addr 0x10 wdata 0xDEADBEEF wstrb 4'hF accepted at cycle 0 -> data_ok at cycle 3, rdata 0.
REQ-031 SHALL cover: after REQ-030, write 0x10 wdata 0x000000AA wstrb 4'h1, then read 0x10 -> rdata 0xDEADBEAA with data_ok.
REQ-032 SHALL cover: DELAY=0, back-to-back reads of 0x0 and 0x4 with req held high -> addr_ok in cycles 0 and 2, data_ok in cycles 1 and 3.
REQ-033 SHALL cover: ADDR_W=10, write 0x1000 with 0x12345678, then read 0x0 -> 0x12345678 (wrap).
REQ-034 SHALL cover: reset pulsed during WAIT of a write to 0x20 -> no data_ok, a later read of 0x20 returns the old value, and addr_ok = 1 after release.
REQ-035 SHALL cover: macro on, three reads accepted back-to-back -> wait counts 5, 3 and 7 after reset, so data_ok comes 6, 4 and 8 cycles after each acceptance.
